// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys single-cycle core: opcodes, functs,
// ALU operations, decoder control word and MMIO addresses.
package minisys_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [31:0] IO_SW_ADDR  = 32'hFFFFFC70;
  localparam logic [31:0] IO_LED_ADDR = 32'hFFFFFC60;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     imm_src;
    logic     imm_zext;
    logic     var_shift;
    logic     reg_we;
    dst_sel_e dst_sel;
    logic     mem_rd;
    logic     mem_wr;
    logic     branch;
    logic     branch_ne;
    logic     jump;
    logic     link;
    logic     jr;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/minisys_alu.sv
// 32-bit combinational ALU; shifts operate on b_i, lui places b_i[15:0] high.
module minisys_alu
  import minisys_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_SLL:  result_o = b_i << shamt_i;
      ALU_SRL:  result_o = b_i >> shamt_i;
      ALU_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
      ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/minisys_cpu.sv
// Minisys single-cycle MIPS-subset core with internal ROM/RAM and 24-bit MMIO.
// Define CPU_IO_SYNC_EN to pass the switch inputs through a 2-flop synchronizer.
module minisys_cpu
  import minisys_pkg::*;
#(
  parameter int    IMEM_AW   = 14,
  parameter int    DMEM_AW   = 14,
  parameter string IMEM_INIT = "prgmip32.mem",
  parameter string DMEM_INIT = "dmem32.mem"
) (
  input  logic        clk,
  input  logic        fpga_rst,
  input  logic        start_uart,
  input  logic        rx,
  output logic        tx,
  input  logic [23:0] io_rdata,
  output logic [23:0] io_wdata
);

  logic [31:0] imem [0:(2**IMEM_AW)-1];
  logic [31:0] dmem [0:(2**DMEM_AW)-1];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic        run;

  assign run   = ~start_uart;
  assign instr = imem[pc_q[IMEM_AW+1:2]];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  ctrl_t ctrl;

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.dst_sel = DST_RT;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_we  = 1'b1;
        ctrl.dst_sel = DST_RD;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_op = ALU_SUB;
          F_AND:  ctrl.alu_op = ALU_AND;
          F_OR:   ctrl.alu_op = ALU_OR;
          F_XOR:  ctrl.alu_op = ALU_XOR;
          F_NOR:  ctrl.alu_op = ALU_NOR;
          F_SLT:  ctrl.alu_op = ALU_SLT;
          F_SLTU: ctrl.alu_op = ALU_SLTU;
          F_SLL:  ctrl.alu_op = ALU_SLL;
          F_SRL:  ctrl.alu_op = ALU_SRL;
          F_SRA:  ctrl.alu_op = ALU_SRA;
          F_SLLV: begin ctrl.alu_op = ALU_SLL; ctrl.var_shift = 1'b1; end
          F_SRLV: begin ctrl.alu_op = ALU_SRL; ctrl.var_shift = 1'b1; end
          F_SRAV: begin ctrl.alu_op = ALU_SRA; ctrl.var_shift = 1'b1; end
          F_JR:   begin ctrl.reg_we = 1'b0; ctrl.jr = 1'b1; end
          default: ctrl.reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin ctrl.imm_src = 1'b1; ctrl.reg_we = 1'b1; end
      OP_SLTI:  begin ctrl.imm_src = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLT;  end
      OP_SLTIU: begin ctrl.imm_src = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLTU; end
      OP_ANDI: begin
        ctrl.imm_src = 1'b1; ctrl.imm_zext = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctrl.imm_src = 1'b1; ctrl.imm_zext = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_OR;
      end
      OP_XORI: begin
        ctrl.imm_src = 1'b1; ctrl.imm_zext = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_XOR;
      end
      OP_LUI:  begin ctrl.imm_src = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_LUI; end
      OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_BNE:  begin ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_LW:   begin ctrl.imm_src = 1'b1; ctrl.reg_we = 1'b1; ctrl.mem_rd = 1'b1; end
      OP_SW:   begin ctrl.imm_src = 1'b1; ctrl.mem_wr = 1'b1; end
      OP_J:    ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_we = 1'b1; ctrl.dst_sel = DST_RA;
      end
      default: ;
    endcase
  end

  // Register file: $0 is never written, so reads of it always see the reset value.
  logic [31:0] rf_q [0:31];
  logic [31:0] rs_val, rt_val, wb_data;
  logic [4:0]  wa;

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  always_comb begin
    wa = rt;
    case (ctrl.dst_sel)
      DST_RD:  wa = rd;
      DST_RT:  wa = rt;
      DST_RA:  wa = 5'd31;
      default: wa = rt;
    endcase
  end

  logic [31:0] imm_ext, alu_b, alu_res;
  logic [4:0]  alu_sh;
  logic        alu_zero;

  assign imm_ext = ctrl.imm_zext ? {16'h0000, imm} : sext16(imm);
  assign alu_b   = ctrl.imm_src ? imm_ext : rt_val;
  assign alu_sh  = ctrl.var_shift ? rs_val[4:0] : shamt;

  minisys_alu u_alu (
    .a_i      (rs_val),
    .b_i      (alu_b),
    .op_i     (ctrl.alu_op),
    .shamt_i  (alu_sh),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  logic [23:0] sw_val;

`ifdef CPU_IO_SYNC_EN
  logic [23:0] sw_s1_q, sw_s2_q;
  always_ff @(posedge clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= io_rdata;
      sw_s2_q <= sw_s1_q;
    end
  end
  assign sw_val = sw_s2_q;
`else
  assign sw_val = io_rdata;
`endif

  // The top 1KB of the address space is the I/O page; only two words are live.
  logic        is_io, io_sw, io_led;
  logic [31:0] rdata;
  logic [23:0] io_wdata_q;

  assign is_io  = (alu_res[31:10] == 22'h3FFFFF);
  assign io_sw  = is_io && (alu_res[9:2] == IO_SW_ADDR[9:2]);
  assign io_led = is_io && (alu_res[9:2] == IO_LED_ADDR[9:2]);

  always_comb begin
    if (io_sw)       rdata = {8'h00, sw_val};
    else if (io_led) rdata = {8'h00, io_wdata_q};
    else if (is_io)  rdata = 32'd0;
    else             rdata = dmem[alu_res[DMEM_AW+1:2]];
  end

  logic [31:0] pc_plus4;
  logic        br_taken;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_taken = ctrl.branch && (alu_zero ^ ctrl.branch_ne);
  assign wb_data  = ctrl.link ? pc_plus4 : (ctrl.mem_rd ? rdata : alu_res);

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jr)       pc_d = rs_val;
    else if (ctrl.jump) pc_d = {pc_plus4[31:28], target, 2'b00};
    else if (br_taken) pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      pc_q       <= '0;
      io_wdata_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (run) begin
      pc_q <= pc_d;
      if (ctrl.reg_we && (wa != 5'd0)) rf_q[wa] <= wb_data;
      if (ctrl.mem_wr && io_led) io_wdata_q <= rt_val[23:0];
    end
  end

  // RAM has no reset; contents survive fpga_rst.
  always_ff @(posedge clk) begin
    if (fpga_rst && run && ctrl.mem_wr && !is_io)
      dmem[alu_res[DMEM_AW+1:2]] <= rt_val;
  end

  assign io_wdata = io_wdata_q;
  assign tx       = 1'b1;

  logic unused_rx;
  assign unused_rx = rx;

endmodule

// File: tb/tb_minisys_cpu.sv
// Scoreboard bench for minisys_cpu: the program reports its results on the LEDs,
// and a monitor pops the expected LED value on every change.
module tb_minisys_cpu;

  logic        clk = 1'b0;
  logic        fpga_rst;
  logic        start_uart;
  logic        rx;
  logic        tx;
  logic [23:0] io_rdata;
  logic [23:0] io_wdata;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_q [$];
  logic [23:0] last_led = 24'h0;
  logic [31:0] prog [0:63];
  logic [31:0] pc_frozen, pc_exp;

  minisys_cpu #(
    .IMEM_AW   (14),
    .DMEM_AW   (14),
    .IMEM_INIT (""),
    .DMEM_INIT ("")
  ) dut (
    .clk        (clk),
    .fpga_rst   (fpga_rst),
    .start_uart (start_uart),
    .rx         (rx),
    .tx         (tx),
    .io_rdata   (io_rdata),
    .io_wdata   (io_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    logic [31:0] w;
    w = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int tgt);
    logic [31:0] w;
    w = {op[5:0], tgt[25:0]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d LED values outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every LED change must match the next queued expectation.
  always @(negedge clk) begin
    if (io_wdata !== last_led) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL led_unexpected: got %h expected no change from %h", io_wdata, last_led);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (io_wdata !== e) begin
          errors++;
          $display("FAIL led_value: got %h expected %h", io_wdata, e);
        end
      end
      last_led = io_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0]  = i_ins(8'h0f, 0, 1, 16'hFFFF);        // lui  $1,0xFFFF
    prog[1]  = i_ins(8'h0d, 1, 1, 16'hFC00);        // ori  $1,$1,0xFC00
    prog[2]  = i_ins(8'h08, 0, 3, 16'hFFFF);        // addi $3,$0,-1
    prog[3]  = r_ins(0, 3, 4, 0, 8'h2b);            // sltu $4,$0,$3
    prog[4]  = r_ins(0, 3, 5, 0, 8'h2a);            // slt  $5,$0,$3
    prog[5]  = r_ins(0, 3, 6, 4, 8'h03);            // sra  $6,$3,4
    prog[6]  = i_ins(8'h2b, 1, 4, 16'h0060);        // sw   $4,0x60($1)
    prog[7]  = i_ins(8'h2b, 1, 5, 16'h0060);        // sw   $5
    prog[8]  = i_ins(8'h2b, 1, 6, 16'h0060);        // sw   $6
    prog[9]  = i_ins(8'h04, 5, 0, 2);               // beq  $5,$0,+2
    prog[10] = i_ins(8'h2b, 1, 0, 16'h0060);        // skipped
    prog[11] = i_ins(8'h2b, 1, 0, 16'h0060);        // skipped
    prog[12] = j_ins(8'h03, 16'h0010);              // jal  0x40
    prog[13] = i_ins(8'h2b, 1, 31, 16'h0060);       // sw   $31
    prog[14] = j_ins(8'h02, 24);                    // j    0x60
    prog[16] = i_ins(8'h08, 31, 10, 16'h0100);      // addi $10,$31,0x100
    prog[17] = i_ins(8'h2b, 1, 10, 16'h0060);       // sw   $10
    prog[18] = r_ins(31, 0, 0, 0, 8'h08);           // jr   $31
    prog[24] = i_ins(8'h0f, 0, 7, 16'h1234);        // lui  $7,0x1234
    prog[25] = i_ins(8'h0d, 7, 7, 16'h5678);        // ori  $7,$7,0x5678
    prog[26] = i_ins(8'h2b, 0, 7, 16'h0010);        // sw   $7,0x10($0)
    prog[27] = i_ins(8'h23, 0, 8, 16'h0010);        // lw   $8,0x10($0)
    prog[28] = i_ins(8'h2b, 1, 8, 16'h0060);        // sw   $8
    prog[29] = r_ins(0, 8, 9, 8, 8'h02);            // srl  $9,$8,8
    prog[30] = i_ins(8'h2b, 1, 9, 16'h0060);        // sw   $9
    prog[31] = i_ins(8'h08, 0, 0, 16'h0055);        // addi $0,$0,0x55
    prog[32] = i_ins(8'h2b, 1, 0, 16'h0060);        // sw   $0
    prog[33] = i_ins(8'h23, 1, 2, 16'h0070);        // lw   $2,0x70($1)
    prog[34] = i_ins(8'h2b, 1, 2, 16'h0060);        // sw   $2,0x60($1)
    prog[35] = j_ins(8'h02, 33);                    // j    loop
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

    fpga_rst   = 1'b0;
    start_uart = 1'b1;
    rx         = 1'b1;
    io_rdata   = 24'hFFFF01;
    repeat (250) @(negedge clk);
    start_uart = 1'b0;
    repeat (250) @(negedge clk);
    chk("reset_pc", dut.pc_q, 32'h0);
    chk("reset_led", {8'h0, io_wdata}, 32'h0);
    chk("reset_tx", {31'h0, tx}, 32'h1);

    exp_q.push_back(24'h000001);   // sltu
    exp_q.push_back(24'h000000);   // slt
    exp_q.push_back(24'hFFFFFF);   // sra
    exp_q.push_back(24'h000134);   // subroutine: $31+0x100
    exp_q.push_back(24'h000034);   // $31 after jal at 0x30
    exp_q.push_back(24'h345678);   // RAM round trip
    exp_q.push_back(24'h123456);   // srl
    exp_q.push_back(24'h000000);   // $0 stays zero
    exp_q.push_back(24'hFFFF01);   // switch loop
    fpga_rst = 1'b1;
    chk("first_fetch", dut.instr, prog[0]);
    drain("program", 300);
    chk("tx_idle", {31'h0, tx}, 32'h1);

    exp_q.push_back(24'hFFFF09);
    io_rdata = 24'hFFFF09;
    drain("switch_follow", 8);

    @(negedge clk);
    start_uart = 1'b1;
    pc_frozen  = dut.pc_q;
    io_rdata   = 24'hFFFF0A;
    repeat (20) @(negedge clk);
    chk("halt_pc", dut.pc_q, pc_frozen);
    chk("halt_led", {8'h0, io_wdata}, 32'h00FFFF09);

    pc_exp = (pc_frozen == 32'd140) ? 32'd132 : pc_frozen + 32'd4;
    exp_q.push_back(24'hFFFF0A);
    start_uart = 1'b0;
    @(negedge clk);
    chk("resume_pc", dut.pc_q, pc_exp);
    drain("resume_led", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
